// File: rtl/lcd_button_debounce_if.sv
// Pushbutton pin and debounced outputs, grouped so that the board side (master)
// and the debouncer (slave) connect through one port.
interface lcd_button_debounce_if;
  logic button_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_repeat;

  modport master (
    output button_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  button_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/lcd_button_debounce.sv
// Pushbutton debouncer: two-flop synchronizer, four-state debounce FSM and
// press/release pulses. Optional auto-repeat is built when LCD_BTN_REPEAT_EN is defined.
module lcd_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd_button_debounce_if.slave  btn
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic            LVL_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_sample;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;

  // Synchronizer resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= LVL_IDLE;
      r_sync2 <= LVL_IDLE;
    end else begin
      r_sync1 <= btn.button_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2 ^ LVL_IDLE;

  // Debounce FSM; level and edge pulses are updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_RELEASED: begin
          if (w_sample) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!w_sample) begin
            r_state <= S_RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PRESSED: begin
          if (!w_sample) begin
            r_state <= S_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (w_sample) begin
            r_state <= S_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_RELEASED;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign btn.btn_level   = r_level;
  assign btn.btn_press   = r_press;
  assign btn.btn_release = r_release;

`ifdef LCD_BTN_REPEAT_EN
  localparam int            RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW       = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DLY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_armed;
  logic          r_repeat;
  logic          w_stay;
  logic [RW-1:0] w_rep_target;

  // Counting only while PRESSED is kept, so any excursion restarts from the initial delay.
  assign w_stay       = (r_state == S_PRESSED) && w_sample;
  assign w_rep_target = r_rep_armed ? RPT_PER : RPT_DLY;

  // Auto-repeat: first pulse after the delay, then one per period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (w_stay) begin
        if (r_rep_cnt == w_rep_target) begin
          r_repeat    <= 1'b1;
          r_rep_cnt   <= '0;
          r_rep_armed <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + RW'(1);
        end
      end else begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end
    end
  end

  assign btn.btn_repeat = r_repeat;
`else
  assign btn.btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_button_debounce.sv
// Randomized scoreboard bench for lcd_button_debounce against a run-length reference model.
module tb_lcd_button_debounce;
  localparam int D  = 4;
  localparam int AL = 1;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_button_debounce_if bif ();

  lcd_button_debounce #(
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (AL),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  logic [3:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: the level flips once D+1 consecutive sampled cycles disagree with it;
  // samples lag the pin by two edges; repeat pulses at hold counts RD, RD+RP, ...
  initial begin
    bit h1, h2, s, lvl, p, r, rp, pre_pressed;
    int run, hold;
    h1 = 1'b0; h2 = 1'b0; lvl = 1'b0; run = 0; hold = 0;
    forever begin
      @(posedge clk);
      cyc++;
      p = 1'b0; r = 1'b0; rp = 1'b0;
      if (reset) begin
        h1 = 1'b0; h2 = 1'b0; lvl = 1'b0; run = 0; hold = 0;
      end else begin
        s  = h2;
        h2 = h1;
        h1 = bif.button_raw ^ (AL != 0);
        pre_pressed = lvl && (run == 0);
        if (s != lvl) begin
          run++;
          if (run == D + 1) begin
            lvl = s;
            run = 0;
            p   = s;
            r   = !s;
          end
        end else begin
          run = 0;
        end
        if (pre_pressed && lvl && run == 0) begin
          hold++;
`ifdef LCD_BTN_REPEAT_EN
          rp = (hold >= RD) && (((hold - RD) % RP) == 0);
`endif
        end else begin
          hold = 0;
        end
      end
      exp_q.push_back({lvl, p, r, rp});
    end
  end

  // Monitor: compare DUT outputs each cycle against the queued expectation.
  initial begin
    logic [3:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %b expected %b (level,press,release,repeat)",
                   cyc, a, e);
        end
      end
    end
  end

  task automatic check_outputs(input string what, input logic [3:0] exp_v, input logic [3:0] mask);
    logic [3:0] got_v;
    got_v = {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat};
    checks++;
    if ((got_v & mask) !== (exp_v & mask)) begin
      errors++;
      $display("FAIL %s: got %b expected %b mask %b (level,press,release,repeat)",
               what, got_v, exp_v, mask);
    end
  endtask

  task automatic hold_raw(input bit v, input int n);
    bif.button_raw = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    check_outputs("reset state", 4'b0000, 4'b1111);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bif.button_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("initial reset state", 4'b0000, 4'b1111);
    reset = 1'b0;
    hold_raw(1'b1, 4);
    // Clean press, long hold for repeat, then clean release
    hold_raw(1'b0, 45);
    check_outputs("press wait expired", 4'b1000, 4'b1000);
    hold_raw(1'b1, 15);
    check_outputs("release wait expired", 4'b0000, 4'b1000);
    // Short bounces that must be ignored
    for (int i = 0; i < 3; i++) begin
      hold_raw(1'b0, 3);
      hold_raw(1'b1, 4);
    end
    // Boundary: D sampled cycles is ignored, D+1 is accepted
    hold_raw(1'b0, 4);
    hold_raw(1'b1, 6);
    hold_raw(1'b0, 5);
    hold_raw(1'b1, 1);
    hold_raw(1'b0, 12);
    hold_raw(1'b1, 12);
    // Reset during press wait while the button stays held
    hold_raw(1'b0, 4);
    pulse_reset(2);
    hold_raw(1'b0, 20);
    // Release aborted back into pressed restarts the repeat delay
    hold_raw(1'b1, 3);
    hold_raw(1'b0, 25);
    hold_raw(1'b1, 15);
    // Random bouncing with occasional long holds and resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        pulse_reset($urandom_range(1, 3));
      end
      if ($urandom_range(0, 9) == 0) begin
        hold_raw(1'($urandom_range(0, 1)), $urandom_range(20, 40));
      end else begin
        hold_raw(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      end
    end
    hold_raw(1'b1, 20);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_button_debounce.md
LCD_BUTTON_DEBOUNCE -- requirements
Module: lcd_button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable samples required to accept a level change; legal range >= 2.
REQ-002 Parameter ACTIVE_LOW, default 1: raw pin reads 0 when pressed (DE-board KEY pins).
REQ-003 Parameter REPEAT_DELAY, default 25000000: cycles held in PRESSED before the first repeat pulse; used only with LCD_BTN_REPEAT_EN.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between later repeat pulses; used only with LCD_BTN_REPEAT_EN.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 button_raw  input  1  asynchronous, bouncing pushbutton pin.
REQ-008 btn_level  output  1  debounced level, 1 = pressed; drives the button PIO in_port.
REQ-009 btn_press  output  1  one-cycle pulse when btn_level rises.
REQ-010 btn_release  output  1  one-cycle pulse when btn_level falls.
REQ-011 btn_repeat  output  1  one-cycle auto-repeat pulse; constant 0 without LCD_BTN_REPEAT_EN.

Function
REQ-012 button_raw SHALL pass through a two-flop synchronizer; sample = sync2 XOR ACTIVE_LOW, so sample = 1 means pressed.
REQ-013 The FSM SHALL have states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus one debounce counter of width clog2(DEBOUNCE_CYCLES).
REQ-014 RELEASED: sample=1 -> PRESS_WAIT with counter=0; otherwise stay.
REQ-015 PRESS_WAIT: sample=0 -> RELEASED with counter=0, and no output changes; sample=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter+1.
REQ-016 PRESSED: sample=0 -> RELEASE_WAIT with counter=0; otherwise stay.
REQ-017 RELEASE_WAIT: mirrors PRESS_WAIT with polarity inverted; on abort -> PRESSED, on completion -> RELEASED.
REQ-018 btn_level SHALL be registered: 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
REQ-019 btn_press and btn_release SHALL be registered and high for exactly the cycle after the corresponding btn_level transition edge, never both at once.
REQ-020 Latency: counting the edge that first captures the new raw level into sync1 as edge 1, btn_level SHALL change on edge DEBOUNCE_CYCLES+3.
REQ-021 Any bounce shorter than DEBOUNCE_CYCLES consecutive sampled cycles SHALL cause no change on any output.
REQ-022 The counter SHALL never wrap; it is cleared on every state entry.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL load:
- sync1 and sync2 = ACTIVE_LOW (released level)
- state = RELEASED, counter = 0, repeat counter = 0
- all outputs = 0
REQ-024 Reset asserted mid-wait SHALL abandon the count with no pulse.
REQ-025 A button held through reset release SHALL be re-debounced and SHALL produce btn_press per REQ-020.

Configuration
REQ-026 Macro LCD_BTN_REPEAT_EN defined:
- In PRESSED, a repeat counter counts cycles.
- btn_repeat pulses once after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
- The repeat counter clears on leaving PRESSED and does not run in RELEASE_WAIT.
- A release that is aborted back into PRESSED restarts the count from REPEAT_DELAY.
REQ-027 Macro undefined: no repeat logic is synthesized; btn_repeat is tied to 0.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 button_raw 1->0, held -> btn_level rises on edge 7 after capture; btn_press high one cycle; btn_release stays 0.
REQ-029 button_raw low for 3 cycles, then high, then repeated -> btn_level, btn_press and btn_release all remain 0.
REQ-030 Pressed and stable, then raw released for 10 cycles -> btn_level falls after 7 edges; one btn_release pulse.
REQ-031 Button held; reset pulsed 2 cycles during PRESS_WAIT -> outputs 0 during reset; btn_press occurs 7 edges after reset release.
REQ-032 Macro defined; held 30 cycles after btn_press -> btn_repeat pulses at PRESSED cycles 10, 13, 16, ...; none after release.
REQ-033 Macro undefined; same stimulus as REQ-032 -> btn_repeat constant 0.
